// File: rtl/div_unit_if.sv
// Execute-stage divide handshake: the E stage (master) requests a divide, the divider (slave)
// returns a one-cycle ready pulse with registered quotient/remainder.
interface div_unit_if #(
    parameter int WIDTH = 32
);
    // StartDivE acts as valid and stays high until DivReadyE (the ready) is seen; a request is
    // consumed in the cycle where both are high, and AnnulE cancels any outstanding request.
    logic             StartDivE;
    logic             SignedDivE;
    logic             AnnulE;
    logic [WIDTH-1:0] SrcAE;
    logic [WIDTH-1:0] SrcBE;
    logic             DivReadyE;
    logic [WIDTH-1:0] DivResultLO;
    logic [WIDTH-1:0] DivResultHI;

    modport master (
        output StartDivE, SignedDivE, AnnulE, SrcAE, SrcBE,
        input  DivReadyE, DivResultLO, DivResultHI
    );

    modport slave (
        input  StartDivE, SignedDivE, AnnulE, SrcAE, SrcBE,
        output DivReadyE, DivResultLO, DivResultHI
    );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle, signs applied
// after the last step. Quotient is returned on LO, remainder on HI.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    div_unit_if.slave  divIf,
    output logic [1:0] divState
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, nextState;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] rem, quo, divisor;
    logic             qNeg, rNeg;

    logic             startDiv, stepEn, lastStep, finish;
    logic             signA, signB, divZero, noBorrow;
    logic [WIDTH-1:0] magA, magB, remNext, quoNext, loNext, hiNext;
    logic [WIDTH:0]   trial;

    assign divState = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (divIf.StartDivE && !divIf.AnnulE) nextState = BUSY;
            BUSY: begin
                if (divIf.AnnulE)  nextState = IDLE;
                else if (lastStep) nextState = DONE;
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    assign startDiv = (state == IDLE) && divIf.StartDivE && !divIf.AnnulE;
    assign stepEn   = (state == BUSY) && !divIf.AnnulE;
    assign lastStep = (count == CNT_W'(WIDTH - 1));
    assign finish   = stepEn && lastStep;

    assign divIf.DivReadyE = (state == DONE) && !divIf.AnnulE;

    // Operand conditioning on the start cycle.
    assign signA   = divIf.SignedDivE & divIf.SrcAE[WIDTH-1];
    assign signB   = divIf.SignedDivE & divIf.SrcBE[WIDTH-1];
    assign divZero = (divIf.SrcBE == '0);
    assign magA    = signA ? -divIf.SrcAE : divIf.SrcAE;
    assign magB    = signB ? -divIf.SrcBE : divIf.SrcBE;

    // One restoring step: shift {rem,quo} left, trial-subtract, keep the difference if no borrow.
    assign trial    = {rem, quo[WIDTH-1]} - {1'b0, divisor};
    assign noBorrow = ~trial[WIDTH];
    assign remNext  = noBorrow ? trial[WIDTH-1:0] : {rem[WIDTH-2:0], quo[WIDTH-1]};
    assign quoNext  = {quo[WIDTH-2:0], noBorrow};
    assign loNext   = qNeg ? -quoNext : quoNext;
    assign hiNext   = rNeg ? -remNext : remNext;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count             <= '0;
            rem               <= '0;
            quo               <= '0;
            divisor           <= '0;
            qNeg              <= 1'b0;
            rNeg              <= 1'b0;
            divIf.DivResultLO <= '0;
            divIf.DivResultHI <= '0;
        end else begin
            if (startDiv) begin
                count   <= '0;
                rem     <= '0;
                divisor <= magB;
                // A zero divisor runs the raw dividend unsigned: the loop then yields an
                // all-ones quotient and shifts the dividend out unchanged as the remainder.
                quo     <= divZero ? divIf.SrcAE : magA;
                qNeg    <= divZero ? 1'b0 : (signA ^ signB);
                rNeg    <= divZero ? 1'b0 : signA;
            end else if (stepEn) begin
                count <= count + CNT_W'(1);
                rem   <= remNext;
                quo   <= quoNext;
            end
            if (finish) begin
                divIf.DivResultLO <= loNext;
                divIf.DivResultHI <= hiNext;
            end
        end
    end
endmodule
